// File: rtl/mem_bus_initiator_pkg.sv
// rtl/mem_bus_initiator_pkg.sv - bus widths, access sizes and FSM states for the memory initiator
package memory_bus_sizes;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } mem_size_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_WR_WAIT  = 3'd4,
      ST_RESP     = 3'd5
   } state_t;

   // Encoding 3 behaves as a full word everywhere.
   function automatic logic is_word(input mem_size_t size);
      return (size == SZ_WORD) || (size == SZ_RSVD);
   endfunction

   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lsb);
      return ((size == SZ_HALF) && lsb[0]) || (is_word(size) && (lsb != 2'b00));
   endfunction

endpackage

// File: rtl/mem_bus_initiator_lane_align.sv
// rtl/mem_bus_initiator_lane_align.sv - byte/halfword lane extraction and store merge
module mem_lane_align
   import memory_bus_sizes::*;
(
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [1:0]            addr_i,
   input  mem_size_t             size_i,
   input  logic                  unsigned_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] load_ext_o,
   output logic [DATA_WIDTH-1:0] merged_word_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = word_i[{addr_i, 3'b000} +: 8];
   assign half_lane = word_i[{addr_i[1], 4'b0000} +: 16];

   always_comb begin
      load_ext_o = word_i;
      case (size_i)
         SZ_BYTE: load_ext_o = {{(DATA_WIDTH-8){byte_lane[7] & ~unsigned_i}}, byte_lane};
         SZ_HALF: load_ext_o = {{(DATA_WIDTH-16){half_lane[15] & ~unsigned_i}}, half_lane};
         default: load_ext_o = word_i;
      endcase
   end

   // The bus has no byte enables, so the untouched lanes come from the word just read.
   always_comb begin
      merged_word_o = word_i;
      case (size_i)
         SZ_BYTE: merged_word_o[{addr_i, 3'b000} +: 8]     = wdata_i[7:0];
         SZ_HALF: merged_word_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         default: merged_word_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/mem_bus_initiator.sv
// rtl/mem_bus_initiator.sv - single-request load/store initiator for the word-wide memory bus
module mem_bus_initiator
   import memory_bus_sizes::*;
#(
   parameter int MEM_DELAY = 10,
   parameter int TIMEOUT   = 255,
   parameter int CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic                  read_addr_valid,
   input  logic                  read_addr_ready,
   input  logic [DATA_WIDTH-1:0] read_data,
   input  logic                  read_data_valid,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic                  write_addr_valid,
   input  logic                  write_addr_ready,
   output logic [DATA_WIDTH-1:0] write_data
);

   localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   if (MEM_DELAY < 1) begin : g_bad_delay
      $error("MEM_DELAY must be at least 1");
   end
   if (TIMEOUT >= (1 << CNT_WIDTH)) begin : g_bad_cnt
      $error("CNT_WIDTH too narrow for TIMEOUT");
   end

   state_t                 state_q, state_d;
   logic                   we_q, we_d;
   mem_size_t              size_q, size_d;
   logic                   uns_q, uns_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0]  load_ext;
   logic [DATA_WIDTH-1:0]  merged_word;
   logic                   bus_state;
   logic                   timeout_hit;

   mem_lane_align u_align (
      .word_i        (read_data),
      .addr_i        (addr_q[1:0]),
      .size_i        (size_q),
      .unsigned_i    (uns_q),
      .wdata_i       (wdata_q),
      .load_ext_o    (load_ext),
      .merged_word_o (merged_word)
   );

   assign bus_state   = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT) ||
                        (state_q == ST_WR_ISSUE) || (state_q == ST_WR_WAIT);
   assign timeout_hit = (TIMEOUT != 0) && bus_state && (cnt_q == TO_LAST);

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      size_d    = size_q;
      uns_d     = uns_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_data_d = wr_data_q;
      rdata_d   = rdata_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = mem_size_t'(req_size);
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               if (is_misaligned(mem_size_t'(req_size), req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (req_we && is_word(mem_size_t'(req_size))) begin
                  wr_data_d = req_wdata;
                  state_d   = ST_WR_ISSUE;
               end else begin
                  state_d = ST_RD_ISSUE;
               end
            end
         end
         ST_RD_ISSUE: begin
            if (read_addr_ready) begin
               state_d = ST_RD_WAIT;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end
         end
         ST_RD_WAIT: begin
            if (read_data_valid) begin
               if (we_q) begin
                  wr_data_d = merged_word;
                  state_d   = ST_WR_ISSUE;
               end else begin
                  rdata_d = load_ext;
                  state_d = ST_RESP;
               end
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end
         end
         ST_WR_ISSUE: begin
            if (write_addr_ready) begin
               state_d = ST_WR_WAIT;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end
         end
         ST_WR_WAIT: begin
            if (read_data_valid) begin
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Valids follow the next state, so they drop the cycle after an accept or abort.
      rd_valid_d = (state_d == ST_RD_ISSUE);
      wr_valid_d = (state_d == ST_WR_ISSUE);

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (bus_state) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_valid_q <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wr_data_q  <= wr_data_d;
         rd_valid_q <= rd_valid_d;
         wr_valid_q <= wr_valid_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign req_ready        = (state_q == ST_IDLE);
   assign resp_valid       = (state_q == ST_RESP);
   assign resp_rdata       = rdata_q;
   assign resp_err         = err_q;
   assign read_addr        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign write_addr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign read_addr_valid  = rd_valid_q;
   assign write_addr_valid = wr_valid_q;
   assign write_data       = wr_data_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb/tb_mem_bus_initiator.sv - directed bench pairing the initiator with a slow RAM model
module tb_mem_bus_initiator;
   import memory_bus_sizes::*;

   localparam int MEM_DELAY = 10;
   localparam int TIMEOUT   = 20;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  req_valid = 1'b0;
   logic                  req_ready;
   logic                  req_we = 1'b0;
   logic [1:0]            req_size = 2'd0;
   logic                  req_unsigned = 1'b0;
   logic [ADDR_WIDTH-1:0] req_addr = '0;
   logic [DATA_WIDTH-1:0] req_wdata = '0;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic                  read_addr_valid;
   logic                  read_addr_ready;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  read_data_valid;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic                  write_addr_valid;
   logic                  write_addr_ready;
   logic [DATA_WIDTH-1:0] write_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_bus_initiator #(.MEM_DELAY(MEM_DELAY), .TIMEOUT(TIMEOUT), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .read_addr(read_addr), .read_addr_valid(read_addr_valid),
      .read_addr_ready(read_addr_ready), .read_data(read_data),
      .read_data_valid(read_data_valid), .write_addr(write_addr),
      .write_addr_valid(write_addr_valid), .write_addr_ready(write_addr_ready),
      .write_data(write_data)
   );

   // slow_ram model: not reset by rst_n, so a read in flight survives an initiator reset
   logic [31:0] mem [0:63];
   logic        ram_busy = 1'b0;
   logic        ram_dv = 1'b0;
   logic        ram_is_wr = 1'b0;
   logic [5:0]  ram_idx = '0;
   logic [31:0] ram_wdata = '0;
   logic [31:0] ram_rdata = '0;
   int          ram_cnt = 0;
   logic        stall = 1'b0;

   assign read_addr_ready  = !ram_busy && !stall;
   assign write_addr_ready = !ram_busy && !stall;
   assign read_data        = ram_rdata;
   assign read_data_valid  = ram_dv;

   always @(posedge clk) begin
      if (ram_busy) begin
         if (ram_dv) begin
            ram_dv   <= 1'b0;
            ram_busy <= 1'b0;
         end else if (ram_cnt == 1) begin
            ram_dv <= 1'b1;
            if (ram_is_wr) mem[ram_idx] <= ram_wdata;
            else ram_rdata <= mem[ram_idx];
         end else begin
            ram_cnt <= ram_cnt - 1;
         end
      end else if (read_addr_valid && read_addr_ready) begin
         ram_busy  <= 1'b1;
         ram_cnt   <= MEM_DELAY;
         ram_is_wr <= 1'b0;
         ram_idx   <= read_addr[7:2];
      end else if (write_addr_valid && write_addr_ready) begin
         ram_busy  <= 1'b1;
         ram_cnt   <= MEM_DELAY;
         ram_is_wr <= 1'b1;
         ram_idx   <= write_addr[7:2];
         ram_wdata <= write_data;
      end
   end

   int          rd_acc = 0;
   int          wr_acc = 0;
   int          both_hi = 0;
   logic [31:0] last_wr = '0;

   always @(posedge clk) begin
      if (read_addr_valid && read_addr_ready) rd_acc <= rd_acc + 1;
      if (write_addr_valid && write_addr_ready) begin
         wr_acc  <= wr_acc + 1;
         last_wr <= write_data;
      end
      if (read_addr_valid && write_addr_valid) both_hi <= both_hi + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issues one request; lat is the resp_valid cycle counted from the accept cycle (0).
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int drd, output int dwr);
      int rd0, wr0, guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      rd0 = rd_acc;
      wr0 = wr_acc;
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!resp_valid) chk("resp_bound", 32'd0, 32'd1);
      rdata = resp_rdata;
      err   = resp_err;
      drd   = rd_acc - rd0;
      dwr   = wr_acc - wr0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, drd, dwr;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'h8899AABB;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rd_valid", {31'd0, read_addr_valid}, 32'd0);
      chk("rst_wr_valid", {31'd0, write_addr_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, drd, dwr);
      chk("lw_data", rd, 32'h8899AABB);
      chk("lw_err", {31'd0, er}, 32'd0);
      chk("lw_lat", lat, MEM_DELAY + 3);
      chk("lw_rd_acc", drd, 32'd1);
      chk("lw_wr_acc", dwr, 32'd0);

      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lat, drd, dwr);
      chk("lb_data", rd, 32'hFFFFFF88);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lat, drd, dwr);
      chk("lbu_data", rd, 32'h00000088);
      do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, lat, drd, dwr);
      chk("lh_data", rd, 32'hFFFF8899);
      do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd, er, lat, drd, dwr);
      chk("lhu_data", rd, 32'h0000AABB);

      do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h55, rd, er, lat, drd, dwr);
      chk("sb_lat", lat, 2 * MEM_DELAY + 5);
      chk("sb_rd_acc", drd, 32'd1);
      chk("sb_wr_acc", dwr, 32'd1);
      chk("sb_wr_word", last_wr, 32'h889955BB);
      chk("sb_rdata", rd, 32'd0);
      chk("sb_err", {31'd0, er}, 32'd0);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, drd, dwr);
      chk("lw_after_sb", rd, 32'h889955BB);

      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, rd, er, lat, drd, dwr);
      chk("sw_lat", lat, MEM_DELAY + 3);
      chk("sw_rd_acc", drd, 32'd0);
      chk("sw_wr_word", last_wr, 32'h12345678);
      do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'hDEADCAFE, rd, er, lat, drd, dwr);
      chk("sh_wr_word", last_wr, 32'hCAFE5678);

      do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, rd, er, lat, drd, dwr);
      chk("lw_mis_err", {31'd0, er}, 32'd1);
      chk("lw_mis_lat", lat, 32'd1);
      chk("lw_mis_bus", drd + dwr, 32'd0);
      do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h77, rd, er, lat, drd, dwr);
      chk("sh_mis_err", {31'd0, er}, 32'd1);
      chk("sh_mis_bus", drd + dwr, 32'd0);

      // reset while the read is outstanding in the RAM
      @(negedge clk);
      req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstw_rd_valid", {31'd0, read_addr_valid}, 32'd0);
      chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, drd, dwr);
      chk("rstw_data", rd, 32'h889955BB);
      chk("rstw_err", {31'd0, er}, 32'd0);
      chk("rstw_rd_acc", drd, 32'd1);
      chk("rstw_waited", {31'd0, lat > MEM_DELAY + 3}, 32'd1);

      stall = 1'b1;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, drd, dwr);
      chk("to_err", {31'd0, er}, 32'd1);
      chk("to_rdata", rd, 32'd0);
      chk("to_lat", lat, TIMEOUT + 1);
      chk("to_rd_acc", drd, 32'd0);
      @(negedge clk);
      chk("to_req_ready", {31'd0, req_ready}, 32'd1);

      // reset while read_addr_valid is held high
      @(negedge clk);
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rsti_valid_hi", {31'd0, read_addr_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rsti_valid_drop", {31'd0, read_addr_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, drd, dwr);
      chk("rsti_lw", rd, 32'hCAFE5678);
      chk("rsti_lat", lat, MEM_DELAY + 3);

      chk("valids_exclusive", both_hi, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
